// File: rtl/ws2812_frame_scheduler_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 frame scheduler.
//   state_e   : scheduler FSM encoding (IDLE/LOAD/SEND/LATCH)
//   digits_t  : snapshot of the four time digits (hours tens..minutes units)
//   scale_grb : per-byte brightness scaling, (ch*(bright+1))>>3
package ws2812_pkg;

  localparam int GRB_W      = 24;
  localparam int NUM_PIXELS = 16;
  localparam int PIX_IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] dh1;
    logic [3:0] dh0;
    logic [2:0] dm1;
    logic [3:0] dm0;
  } digits_t;

  function automatic logic [GRB_W-1:0] scale_grb(input logic [GRB_W-1:0] c,
                                                 input logic [2:0]       b);
    logic [GRB_W-1:0] res;
    logic [10:0]      prod;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      prod = 11'(c[8*i +: 8]) * (11'(b) + 11'd1);
      res[8*i +: 8] = prod[10:3];
    end
    return res;
  endfunction

endpackage

// File: rtl/ws2812_frame_scheduler_binclock_pixel_map.sv
// binclock_pixel_map: combinational lookup of whether a pixel is lit.
//   snap : digit snapshot
//   idx  : pixel index, idx = col*4 + row
//   lit  : 1 when bit 'row' of the digit in column 'col' is set
// Columns: 0=DH1, 1=DH0, 2=DM1, 3=DM0. Bits above a digit's width read as 0.
module binclock_pixel_map
  import ws2812_pkg::*;
(
  input  digits_t              snap,
  input  logic [PIX_IDX_W-1:0] idx,
  output logic                 lit
);

  logic [3:0] digit;

  always_comb begin
    digit = '0;
    case (idx[3:2])
      2'd0:    digit = {2'b00, snap.dh1};
      2'd1:    digit = snap.dh0;
      2'd2:    digit = {1'b0, snap.dm1};
      default: digit = snap.dm0;
    endcase
    lit = digit[idx[1:0]];
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler: sequences one 16-pixel WS2812 frame of the binary clock.
// Ports:
//   CLK, RST (async, active-high)        clock / reset
//   START                                frame request pulse
//   DH1, DH0, DM1, DM0                   time digits, snapshotted in LOAD
//   PIX_DATA, PIX_INDEX, PIX_VALID       pixel stream out (valid/ready)
//   PIX_READY                            serialiser accept
//   BUSY                                 high whenever not IDLE
//   FRAME_DONE                           1-cycle pulse on leaving LATCH
//   DBG_STATE                            current FSM state
//   BRIGHT (WS2812_BRIGHTNESS_EN only)   brightness 0..7, 7 = unscaled
// Handshake: a pixel transfers on a rising edge with PIX_VALID & PIX_READY;
// while PIX_VALID & !PIX_READY, PIX_DATA and PIX_INDEX hold.
// Optional feature macro: WS2812_BRIGHTNESS_EN.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int               LATCH_CYCLES = 960,
  parameter logic [GRB_W-1:0] ON_COLOR     = 24'h00FF00,
  parameter logic [GRB_W-1:0] OFF_COLOR    = 24'h000000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [1:0]           DH1,
  input  logic [3:0]           DH0,
  input  logic [2:0]           DM1,
  input  logic [3:0]           DM0,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [2:0]           BRIGHT,
`endif
  output logic [GRB_W-1:0]     PIX_DATA,
  output logic [PIX_IDX_W-1:0] PIX_INDEX,
  output logic                 PIX_VALID,
  input  logic                 PIX_READY,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output state_e               DBG_STATE
);

  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  state_e               state_q, state_d;
  digits_t              snap_q, snap_d;
  logic                 pending_q, pending_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [PIX_IDX_W-1:0] index_q, index_d;
  logic [GRB_W-1:0]     data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [2:0]           bright_q, bright_d;

  logic [PIX_IDX_W-1:0] nxt_idx;
  logic                 nxt_lit;
  logic [GRB_W-1:0]     on_col, off_col, nxt_data;

  // Pixel to present next: 0 on SEND entry, otherwise the one after the current.
  assign nxt_idx = (state_q == ST_SEND && valid_q) ? index_q + 4'd1 : '0;

  binclock_pixel_map u_map (
    .snap (snap_q),
    .idx  (nxt_idx),
    .lit  (nxt_lit)
  );

`ifdef WS2812_BRIGHTNESS_EN
  assign on_col  = scale_grb(ON_COLOR, bright_q);
  assign off_col = scale_grb(OFF_COLOR, bright_q);
`else
  assign on_col  = ON_COLOR;
  assign off_col = OFF_COLOR;
`endif
  assign nxt_data = nxt_lit ? on_col : off_col;

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    index_d      = index_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    bright_d     = bright_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        snap_d    = {DH1, DH0, DM1, DM0};
`ifdef WS2812_BRIGHTNESS_EN
        bright_d  = BRIGHT;
`else
        bright_d  = 3'd7;
`endif
        pending_d = pending_q | START;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        pending_d = pending_q | START;
        if (!valid_q) begin
          valid_d = 1'b1;
          index_d = nxt_idx;
          data_d  = nxt_data;
        end else if (PIX_READY) begin
          if (index_q == PIX_IDX_W'(NUM_PIXELS - 1)) begin
            valid_d = 1'b0;
            cnt_d   = CNT_W'(LATCH_CYCLES - 1);
            state_d = ST_LATCH;
          end else begin
            index_d = nxt_idx;
            data_d  = nxt_data;
          end
        end
      end
      default: begin
        if (cnt_q == '0) begin
          frame_done_d = 1'b1;
          // A START landing on the exit edge counts as pending.
          state_d      = (pending_q | START) ? ST_LOAD : ST_IDLE;
          pending_d    = 1'b0;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          pending_d = pending_q | START;
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      snap_q       <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      index_q      <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      bright_q     <= 3'd7;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      index_q      <= index_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      bright_q     <= bright_d;
    end
  end

  assign PIX_DATA   = data_q;
  assign PIX_INDEX  = index_q;
  assign PIX_VALID  = valid_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench for ws2812_frame_scheduler.
// Model: each requested frame is a queue entry {bright, dh1, dh0, dm1, dm0};
// pixel colours are derived from the binary-clock rule with plain arithmetic.
module tb_ws2812_frame_scheduler;
  import ws2812_pkg::*;

  localparam int          LATCH = 24;
  localparam logic [23:0] ON    = 24'h00FF00;
  localparam logic [23:0] OFF   = 24'h000000;

  // ---------------- clock / reset / signals ----------------
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  DH1 = '0;
  logic [3:0]  DH0 = '0;
  logic [2:0]  DM1 = '0;
  logic [3:0]  DM0 = '0;
  logic [2:0]  BRIGHT = 3'd7;
  logic        PIX_READY = 1'b1;
  logic [23:0] PIX_DATA;
  logic [3:0]  PIX_INDEX;
  logic        PIX_VALID;
  logic        BUSY;
  logic        FRAME_DONE;
  state_e      DBG_STATE;

  always #5 CLK = ~CLK;

  ws2812_frame_scheduler #(.LATCH_CYCLES(LATCH), .ON_COLOR(ON), .OFF_COLOR(OFF)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .DH1        (DH1),
    .DH0        (DH0),
    .DM1        (DM1),
    .DM0        (DM0),
`ifdef WS2812_BRIGHTNESS_EN
    .BRIGHT     (BRIGHT),
`endif
    .PIX_DATA   (PIX_DATA),
    .PIX_INDEX  (PIX_INDEX),
    .PIX_VALID  (PIX_VALID),
    .PIX_READY  (PIX_READY),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .DBG_STATE  (DBG_STATE)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic        model_on = 1'b0;
  logic        in_frame = 1'b0;
  int          exp_idx  = 0;
  logic [15:0] cur      = '0;
  int          fd_due   = -1;
  int          cyc      = 0;
  int          fd_count = 0;
  int          idx7_cycles = 0;
  logic [23:0] pix0_data = '0;
  logic [15:0] on_mask  = '0;
  int          stall_idx  = -1;
  int          stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(input logic [15:0] e, input int p);
    int dig[4];
    int b;
    int lit;
    logic [23:0] r;
    b      = int'(e[15:13]);
    dig[0] = int'(e[12:11]);
    dig[1] = int'(e[10:7]);
    dig[2] = int'(e[6:4]);
    dig[3] = int'(e[3:0]);
    lit    = (dig[p / 4] >> (p % 4)) & 1;
    r      = (lit != 0) ? ON : OFF;
`ifdef WS2812_BRIGHTNESS_EN
    for (int k = 0; k < 3; k++) r[8*k +: 8] = 8'((int'(r[8*k +: 8]) * (b + 1)) / 8);
`else
    if (b != 7) r = 'x;
`endif
    return r;
  endfunction

  // ---------------- compare process (every cycle) ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (!model_on) continue;
      if (RST) begin
        exp_q.delete();
        in_frame = 1'b0;
        fd_due   = -1;
        continue;
      end
      cyc++;
      check("frame_done", 32'(FRAME_DONE), 32'(fd_due == cyc));
      if (FRAME_DONE) fd_count++;
      if (in_frame || fd_due > cyc) check("busy", 32'(BUSY), 32'd1);
      if (PIX_VALID) begin
        if (!in_frame) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(PIX_VALID), 32'd0);
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            exp_idx  = 0;
            on_mask  = '0;
          end
        end
        if (in_frame) begin
          check("pix_index", 32'(PIX_INDEX), 32'(exp_idx));
          check("pix_data", 32'(PIX_DATA), 32'(model_pix(cur, exp_idx)));
          if (exp_idx == 7) idx7_cycles++;
          if (exp_idx == 0) pix0_data = PIX_DATA;
          if (PIX_DATA != OFF) on_mask[exp_idx] = 1'b1;
          if (PIX_READY) begin
            if (exp_idx == 15) begin
              in_frame = 1'b0;
              fd_due   = cyc + LATCH + 1;
            end else begin
              exp_idx++;
            end
          end
        end
      end else if (in_frame) begin
        check("valid_gap", 32'(PIX_VALID), 32'd1);
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (stall_left > 0 && PIX_VALID === 1'b1 && int'(PIX_INDEX) == stall_idx) begin
        PIX_READY = 1'b0;
        stall_left--;
      end else begin
        PIX_READY = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic set_digits(input int h1, input int h0, input int m1, input int m0);
    DH1 = 2'(h1); DH0 = 4'(h0); DM1 = 3'(m1); DM0 = 4'(m0);
  endtask

  task automatic push_frame();
    exp_q.push_back({BRIGHT, DH1, DH0, DM1, DM0});
  endtask

  task automatic begin_frame(input int h1, input int h0, input int m1, input int m0);
    set_digits(h1, h0, m1, m0);
    push_frame();
    pulse_start();
  endtask

  task automatic wait_done(input int budget);
    int   t;
    logic done;
    t    = 0;
    done = 1'b0;
    while (t < budget && !done) begin
      @(negedge CLK); #1;
      t++;
      done = (exp_q.size() == 0) && !in_frame && (cyc > fd_due);
    end
    check("frame_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(PIX_VALID), 32'd0);
    check({tag, "_index"}, 32'(PIX_INDEX), 32'd0);
    check({tag, "_data"},  32'(PIX_DATA),  32'd0);
    check({tag, "_busy"},  32'(BUSY),      32'd0);
    check({tag, "_fd"},    32'(FRAME_DONE), 32'd0);
    check({tag, "_state"}, 32'(DBG_STATE), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    // 1: reset asserted mid-clock, outputs clear immediately
    #3 RST = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    model_on = 1'b1;
    idle(10);
    check("idle_no_valid", 32'(PIX_VALID), 32'd0);

    // 2: 12:34 frame, latency and lit pattern
    fd_count = 0;
    begin_frame(1, 2, 3, 4);
    check("lat_load_valid", 32'(PIX_VALID), 32'd0);
    check("lat_load_state", 32'(DBG_STATE), 32'(ST_LOAD));
    @(posedge CLK); #1;
    check("lat_n1_valid", 32'(PIX_VALID), 32'd0);
    @(posedge CLK); #1;
    check("lat_n2_valid", 32'(PIX_VALID), 32'd1);
    check("lat_n2_index", 32'(PIX_INDEX), 32'd0);
    wait_done(200);
    check("mask_1234", 32'(on_mask), 32'h4321);
`ifndef WS2812_BRIGHTNESS_EN
    check("pix0_on", 32'(pix0_data), 32'(ON));
`endif
    idle(5);
    check("fd_count_1", 32'(fd_count), 32'd1);
    check("busy_after", 32'(BUSY), 32'd0);

    // 3: backpressure at idx 7 for 3 cycles
    idx7_cycles = 0;
    stall_idx   = 7;
    stall_left  = 3;
    begin_frame(0, 9, 4, 7);
    wait_done(200);
    check("idx7_hold", 32'(idx7_cycles), 32'd4);
    stall_idx = -1;

    // 4: two STARTs mid-frame plus DH0 change -> one follow-up frame
    fd_count = 0;
    begin_frame(1, 2, 3, 4);
    idle(5);
    pulse_start();
    DH0 = 4'd5;
    push_frame();
    idle(4);
    pulse_start();
    wait_done(400);
    idle(LATCH + 10);
    check("fd_count_2", 32'(fd_count), 32'd2);
    check("queue_empty_4", 32'(exp_q.size()), 32'd0);

    // 5: reset at idx 10 with a pending request, then clean restart
    begin_frame(2, 1, 0, 8);
    idle(6);
    pulse_start();
    t = 0;
    while (t < 100 && !(PIX_VALID === 1'b1 && PIX_INDEX == 4'd10)) begin
      @(posedge CLK); #1;
      t++;
    end
    check("reach_idx10", 32'(PIX_INDEX), 32'd10);
    #1 RST = 1'b1;
    #1 check_reset_outputs("midreset");
    @(posedge CLK); #2 RST = 1'b0;
    idle(LATCH + 10);
    check("no_pending_valid", 32'(PIX_VALID), 32'd0);
    fd_count = 0;
    begin_frame(2, 3, 5, 9);
    wait_done(200);
    idle(LATCH + 10);
    check("fd_count_5", 32'(fd_count), 32'd1);

`ifdef WS2812_BRIGHTNESS_EN
    // 6: brightness 3 scales lit green to 0x7F
    BRIGHT = 3'd3;
    begin_frame(1, 2, 3, 4);
    wait_done(200);
    check("bright3_pix0", 32'(pix0_data), 32'h007F00);
    BRIGHT = 3'd7;
`endif

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
